issue_scoreboard: RTL and testbench

ISSUE_SCOREBOARD -- requirements
Module: issue_scoreboard

---
 rtl/issue_scoreboard.sv | 92 +++++++++
 tb/tb_issue_scoreboard.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/issue_scoreboard.sv
// Register-write scoreboard: per-register pending counters gate issue; flush drains outstanding writes before resuming.
// Optional SCOREBOARD_WB_BYPASS_EN lets a same-cycle writeback clear a single-pending RAW hazard.
module issue_scoreboard (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rs1,
  input  logic [4:0]  issue_rs2,
  input  logic        issue_use_rs1,
  input  logic        issue_use_rs2,
  input  logic [4:0]  issue_rd,
  input  logic        issue_rd_w,
  input  logic        stall_in,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic        flush,
  output logic        issue_ready,
  output logic [31:0] busy,
  output logic [3:0]  inflight_cnt,
  output logic        wb_err
);

  typedef enum logic {RUN, DRAIN} state_t;

  state_t      state;
  logic [1:0]  cnt [32];
  logic [3:0]  inflight;
  logic [3:0]  inflight_next;
  logic        haz1;
  logic        haz2;
  logic        rd_full;
  logic        fire;
  logic        inc;
  logic        dec;
  logic        wb_bad;
  logic [31:0] inc_vec;
  logic [31:0] dec_vec;

  always_comb begin
    haz1 = issue_use_rs1 && (issue_rs1 != 5'd0) && (cnt[issue_rs1] != 2'd0);
    haz2 = issue_use_rs2 && (issue_rs2 != 5'd0) && (cnt[issue_rs2] != 2'd0);
`ifdef SCOREBOARD_WB_BYPASS_EN
    if (wb_valid && (wb_rd == issue_rs1) && (cnt[issue_rs1] == 2'd1)) haz1 = 1'b0;
    if (wb_valid && (wb_rd == issue_rs2) && (cnt[issue_rs2] == 2'd1)) haz2 = 1'b0;
`endif
  end

  assign rd_full     = issue_rd_w && (issue_rd != 5'd0) && (cnt[issue_rd] == 2'd3);
  assign issue_ready = (state == RUN) && !haz1 && !haz2 && (inflight != 4'd15) && !rd_full;
  assign fire        = issue_valid && issue_ready && !stall_in && !flush;
  assign inc         = fire && issue_rd_w && (issue_rd != 5'd0);
  assign dec         = wb_valid && (wb_rd != 5'd0) && (cnt[wb_rd] != 2'd0);
  assign wb_bad      = wb_valid && (wb_rd != 5'd0) && (cnt[wb_rd] == 2'd0);
  assign inc_vec     = inc ? (32'd1 << issue_rd) : 32'd0;
  assign dec_vec     = dec ? (32'd1 << wb_rd) : 32'd0;

  always_comb begin
    inflight_next = inflight;
    if (inc && !dec) inflight_next = inflight + 4'd1;
    if (dec && !inc) inflight_next = inflight - 4'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) cnt[i] <= 2'd0;
      inflight <= 4'd0;
      wb_err   <= 1'b0;
      state    <= RUN;
    end else begin
      // Same-register issue and writeback cancel out.
      for (int i = 0; i < 32; i++) begin
        if (inc_vec[i] && !dec_vec[i])      cnt[i] <= cnt[i] + 2'd1;
        else if (dec_vec[i] && !inc_vec[i]) cnt[i] <= cnt[i] - 2'd1;
      end
      inflight <= inflight_next;
      if (wb_bad) wb_err <= 1'b1;
      case (state)
        RUN:     if (flush) state <= DRAIN;
        DRAIN:   if (!flush && (inflight_next == 4'd0)) state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < 32; i++) busy[i] = (cnt[i] != 2'd0);
    busy[0] = 1'b0;
  end

  assign inflight_cnt = inflight;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed table-driven bench for issue_scoreboard plus hand sequences for fill, drain and async reset.
module tb_issue_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic [4:0]  issue_rs1;
  logic [4:0]  issue_rs2;
  logic        issue_use_rs1;
  logic        issue_use_rs2;
  logic [4:0]  issue_rd;
  logic        issue_rd_w;
  logic        stall_in;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        flush;
  logic        issue_ready;
  logic [31:0] busy;
  logic [3:0]  inflight_cnt;
  logic        wb_err;

  int checks   = 0;
  int failures = 0;

`ifdef SCOREBOARD_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  issue_scoreboard dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_use_rs1(issue_use_rs1), .issue_use_rs2(issue_use_rs2), .issue_rd(issue_rd),
    .issue_rd_w(issue_rd_w), .stall_in(stall_in), .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
    .issue_ready(issue_ready), .busy(busy), .inflight_cnt(inflight_cnt), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [4:0]  rs1;
    logic        u1;
    logic [4:0]  rs2;
    logic        u2;
    logic [4:0]  rd;
    logic        w;
    logic        st;
    logic        wbv;
    logic [4:0]  wbrd;
    logic        fl;
    logic        er;   // expected issue_ready before the edge
    logic [31:0] eb;   // expected busy after the edge
    logic [3:0]  ei;   // expected inflight_cnt after the edge
    logic        ee;   // expected wb_err after the edge
  } vec_t;

  function automatic vec_t mk(bit v, int rs1, bit u1, int rs2, bit u2, int rd, bit w, bit st,
                              bit wbv, int wbrd, bit fl, bit er, logic [31:0] eb, int ei, bit ee);
    vec_t t;
    t.v = v; t.rs1 = 5'(rs1); t.u1 = u1; t.rs2 = 5'(rs2); t.u2 = u2; t.rd = 5'(rd); t.w = w;
    t.st = st; t.wbv = wbv; t.wbrd = 5'(wbrd); t.fl = fl; t.er = er; t.eb = eb; t.ei = 4'(ei); t.ee = ee;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    issue_valid = 0; issue_rs1 = 0; issue_rs2 = 0; issue_use_rs1 = 0; issue_use_rs2 = 0;
    issue_rd = 0; issue_rd_w = 0; stall_in = 0; wb_valid = 0; wb_rd = 0; flush = 0;
  endtask

  task automatic apply(input vec_t t, input string name);
    @(negedge clk);
    issue_valid = t.v; issue_rs1 = t.rs1; issue_use_rs1 = t.u1; issue_rs2 = t.rs2; issue_use_rs2 = t.u2;
    issue_rd = t.rd; issue_rd_w = t.w; stall_in = t.st; wb_valid = t.wbv; wb_rd = t.wbrd; flush = t.fl;
    #1;
    chk({name, ".ready"}, 32'(issue_ready), 32'(t.er));
    @(posedge clk);
    #1;
    chk({name, ".busy"}, busy, t.eb);
    chk({name, ".inflight"}, 32'(inflight_cnt), 32'(t.ei));
    chk({name, ".wb_err"}, 32'(wb_err), 32'(t.ee));
  endtask

  vec_t tbl [19];

  initial begin
    logic [31:0] eb;

    //            v rs1 u1 rs2 u2 rd w st wbv wbrd fl  er   busy       inf err
    tbl[0]  = mk(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 1,   32'h20,    1, 0);
    tbl[1]  = mk(1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 0, 0,   32'h20,    1, 0);
    tbl[2]  = mk(1, 5, 1, 0, 0, 6, 0, 0, 1, 5, 0, BYP, 32'h0,     0, 0);
    tbl[3]  = mk(1, 5, 1, 0, 0, 0, 1, 0, 0, 0, 0, 1,   32'h0,     0, 0);
    tbl[4]  = mk(1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 1,   32'h0,     0, 0);
    tbl[5]  = mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 1,   32'h80,    1, 0);
    tbl[6]  = mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 1,   32'h80,    2, 0);
    tbl[7]  = mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 1,   32'h80,    3, 0);
    tbl[8]  = mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0,   32'h80,    3, 0);
    tbl[9]  = mk(1, 0, 0, 0, 0, 7, 1, 0, 1, 7, 0, 0,   32'h80,    2, 0);
    tbl[10] = mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 1,   32'h80,    3, 0);
    tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 1,   32'h80,    2, 0);
    tbl[12] = mk(1, 0, 0, 0, 0, 7, 1, 0, 1, 7, 0, 1,   32'h80,    2, 0);
    tbl[13] = mk(1, 0, 0, 0, 0, 8, 1, 0, 1, 7, 0, 1,   32'h180,   2, 0);
    tbl[14] = mk(1, 0, 0, 0, 0, 9, 1, 1, 0, 0, 0, 1,   32'h180,   2, 0);
    tbl[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 1,   32'h180,   2, 1);
    tbl[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 1,   32'h100,   1, 1);
    tbl[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 8, 0, 1,   32'h0,     0, 1);
    tbl[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1,   32'h0,     0, 1);

    drive_idle();
    rst = 1'b1;
    #2;
    chk("reset.busy", busy, 32'h0);
    chk("reset.inflight", 32'(inflight_cnt), 32'h0);
    chk("reset.wb_err", 32'(wb_err), 32'h0);
    chk("reset.ready", 32'(issue_ready), 32'h1);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 19; i++) apply(tbl[i], $sformatf("tbl%0d", i));

    // Fill fifteen distinct destinations.
    eb = 32'h0;
    for (int i = 1; i <= 15; i++) begin
      eb[i] = 1'b1;
      apply(mk(1, 0, 0, 0, 0, i, 1, 0, 0, 0, 0, 1, eb, i, 1), $sformatf("fill%0d", i));
    end
    apply(mk(0, 0, 0, 0, 0, 16, 1, 0, 0, 0, 0, 0, eb, 15, 1), "full_hold");
    eb[1] = 1'b0;
    apply(mk(0, 0, 0, 0, 0, 16, 1, 0, 1, 1, 0, 0, eb, 14, 1), "full_wb");
    for (int i = 2; i <= 12; i++) begin
      eb[i] = 1'b0;
      apply(mk(0, 0, 0, 0, 0, 16, 1, 0, 1, i, 0, 1, eb, 15 - i, 1), $sformatf("retire%0d", i));
    end

    // Flush with three outstanding writes, including a re-flush while draining.
    apply(mk(1, 0, 0, 0, 0, 20, 1, 0, 0, 0, 1, 1, 32'hE000, 3, 1), "flush");
    apply(mk(1, 0, 0, 0, 0, 20, 1, 0, 1, 13, 0, 0, 32'hC000, 2, 1), "drain13");
    apply(mk(1, 0, 0, 0, 0, 20, 1, 0, 1, 14, 1, 0, 32'h8000, 1, 1), "drain14_flush");
    apply(mk(1, 0, 0, 0, 0, 20, 1, 0, 1, 15, 0, 0, 32'h0, 0, 1), "drain15");
    apply(mk(0, 0, 0, 0, 0, 20, 1, 0, 0, 0, 0, 1, 32'h0, 0, 1), "resumed");

    // Flush with nothing outstanding costs exactly one drain cycle.
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h0, 0, 1), "flush_empty");
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 1), "drain_empty");
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 0, 1), "resumed_empty");

    // Async reset mid-cycle discards a pending write.
    apply(mk(1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0, 1, 32'h200, 1, 1), "pre_rst");
    @(negedge clk);
    drive_idle();
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst.busy", busy, 32'h0);
    chk("async_rst.inflight", 32'(inflight_cnt), 32'h0);
    chk("async_rst.wb_err", 32'(wb_err), 32'h0);
    chk("async_rst.ready", 32'(issue_ready), 32'h1);
    @(negedge clk);
    rst = 1'b0;
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 1, 32'h0, 0, 1), "stale_wb");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
